// File: rtl/video_pkg.sv
// Shared types and helpers for the video bank writer path.
package video_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_CMD      = 3'd2,
        ST_ADDR     = 3'd3,
        ST_DATA     = 3'd4,
        ST_CS_HOLD  = 3'd5
    } spi_ld_state_t;

    localparam int         SPI_ADDR_W       = 24;
    localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;

    // A frame is packed 1 bpp into whole bytes; the last byte may carry pad bits.
    function automatic int frame_bytes(input int width, input int height);
        return (width * height + 7) / 8;
    endfunction

endpackage

// File: rtl/spi_shift_master.sv
// SPI mode-0 bit engine: SCLK toggling, MSB-first shift-out and MISO capture on rising SCLK.
module spi_shift_master
    import video_pkg::*;
#(
    parameter int WORD_W = 8 + SPI_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              run,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              capture_en,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              fall,
    output logic              rx_valid,
    output logic              rx_bit
);

    logic [WORD_W-2:0] shift_reg;
    logic              rise;

    assign rise = tick && run && !sclk;
    assign fall = tick && run && sclk;

    // MOSI always holds the bit under transfer; zeros shift in behind the word so MOSI idles low.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            shift_reg <= '0;
            rx_valid  <= 1'b0;
            rx_bit    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (load) begin
                {mosi, shift_reg} <= load_word;
            end else if (fall) begin
                {mosi, shift_reg} <= {shift_reg, 1'b0};
            end
            if (rise || fall) begin
                sclk <= !sclk;
            end
            if (rise && capture_en) begin
                rx_valid <= 1'b1;
                rx_bit   <= miso;
            end
        end
    end

endmodule

// File: rtl/spi_frame_loader.sv
// Reads one 1-bpp frame per request from SPI flash and streams it into the video bank as x/y writes.
module spi_frame_loader
    import video_pkg::*;
#(
    parameter int                    X_WIDTH    = 8,
    parameter int                    Y_HEIGHT   = 6,
    parameter int                    NUM_FRAMES = 4,
    parameter logic [SPI_ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [7:0]            READ_CMD   = READ_CMD_DEFAULT
) (
    input  logic                        CLK_40,
    input  logic                        reset,
    input  logic                        SPI_clk_en,
    input  logic                        frame_start,
    input  logic                        MISO,
    output logic                        SCLK,
    output logic                        MOSI,
    output logic                        CS_n,
    output logic                        write_enable,
    output logic                        data_in,
    output logic [$clog2(X_WIDTH)-1:0]  mem_x_pos,
    output logic [$clog2(Y_HEIGHT)-1:0] mem_y_pos,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int X_W         = $clog2(X_WIDTH);
    localparam int Y_W         = $clog2(Y_HEIGHT);
    localparam int IDX_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int FRAME_BYTES = frame_bytes(X_WIDTH, Y_HEIGHT);

    localparam logic [X_W-1:0]   X_LAST    = X_W'(X_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(Y_HEIGHT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_FRAMES - 1);
    localparam logic [4:0]       CMD_LAST  = 5'd7;
    localparam logic [4:0]       ADDR_LAST = 5'd31;

    spi_ld_state_t         state;
    logic [IDX_W-1:0]      frame_idx;
    logic [4:0]            bit_cnt;
    logic [SPI_ADDR_W-1:0] frame_addr;
    logic                  accept;
    logic                  shifting;
    logic                  fall;

    assign frame_addr = BASE_ADDR + SPI_ADDR_W'(frame_idx) * SPI_ADDR_W'(FRAME_BYTES);
    // A start in the frame_done cycle is dropped so the bank swap sees a clean boundary.
    assign accept     = (state == ST_IDLE) && frame_start && !frame_done;
    assign shifting   = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);

    spi_shift_master #(
        .WORD_W(8 + SPI_ADDR_W)
    ) u_shift (
        .clk        (CLK_40),
        .reset      (reset),
        .tick       (SPI_clk_en),
        .run        (shifting),
        .load       (accept),
        .load_word  ({READ_CMD, frame_addr}),
        .capture_en (state == ST_DATA),
        .miso       (MISO),
        .sclk       (SCLK),
        .mosi       (MOSI),
        .fall       (fall),
        .rx_valid   (write_enable),
        .rx_bit     (data_in)
    );

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state      <= ST_IDLE;
            CS_n       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_idx  <= '0;
            bit_cnt    <= '0;
            mem_x_pos  <= '0;
            mem_y_pos  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_CS_SETUP;
                        busy    <= 1'b1;
                        CS_n    <= 1'b0;
                        bit_cnt <= '0;
                    end
                end
                ST_CS_SETUP: begin
                    if (SPI_clk_en) begin
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (fall) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == CMD_LAST) begin
                            state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (fall) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == ADDR_LAST) begin
                            state <= ST_DATA;
                        end
                    end
                end
                // Position advances on the falling edge so it stays valid through the write strobe.
                ST_DATA: begin
                    if (fall) begin
                        if (mem_x_pos == X_LAST && mem_y_pos == Y_LAST) begin
                            state     <= ST_CS_HOLD;
                            CS_n      <= 1'b1;
                            mem_x_pos <= '0;
                            mem_y_pos <= '0;
                        end else if (mem_x_pos == X_LAST) begin
                            mem_x_pos <= '0;
                            mem_y_pos <= mem_y_pos + Y_W'(1);
                        end else begin
                            mem_x_pos <= mem_x_pos + X_W'(1);
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (SPI_clk_en) begin
                        state      <= ST_IDLE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        frame_idx  <= (frame_idx == IDX_LAST) ? '0 : frame_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    CS_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Bench for spi_frame_loader: behavioural SPI flash, pixel monitor and frame-level reference model.
module tb_spi_frame_loader;

    localparam int XW       = 8;
    localparam int YH       = 6;
    localparam int NPIX     = XW * YH;
    localparam int MEMSZ    = 256;
    localparam int MAX_WAIT = 4000;

    logic       CLK_40      = 1'b0;
    logic       reset       = 1'b1;
    logic       SPI_clk_en  = 1'b0;
    logic       frame_start = 1'b0;
    logic       MISO        = 1'b0;
    logic       SCLK, MOSI, CS_n, write_enable, data_in, busy, frame_done;
    logic [2:0] mem_x_pos, mem_y_pos;

    spi_frame_loader dut (
        .CLK_40       (CLK_40),
        .reset        (reset),
        .SPI_clk_en   (SPI_clk_en),
        .frame_start  (frame_start),
        .MISO         (MISO),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .CS_n         (CS_n),
        .write_enable (write_enable),
        .data_in      (data_in),
        .mem_x_pos    (mem_x_pos),
        .mem_y_pos    (mem_y_pos),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 CLK_40 = ~CLK_40;

    int n_checks = 0;
    int n_errors = 0;
    int last_base = 0;

    logic [7:0] flash_mem [MEMSZ];

    // Tick generator: tick_max=0 gives a tick every cycle, otherwise gaps of 1..tick_max+1 cycles.
    int tick_max = 0;
    int tick_cnt = 0;
    always @(negedge CLK_40) begin
        if (tick_cnt == 0) begin
            SPI_clk_en = 1'b1;
            tick_cnt   = int'($urandom_range(tick_max, 0));
        end else begin
            SPI_clk_en = 1'b0;
            tick_cnt   = tick_cnt - 1;
        end
    end

    // Flash: 8 opcode + 24 address bits in on rising SCLK, then bytes out MSB first on falling SCLK.
    int          fl_bits  = 0;
    int          fl_out   = 0;
    int          fl_words = 0;
    logic [31:0] fl_in    = '0;
    logic [31:0] fl_word  = '0;
    logic        sclk_q   = 1'b0;
    always @(CS_n or SCLK) begin
        if (CS_n === 1'b1) begin
            fl_bits = 0;
            fl_out  = 0;
        end else if (CS_n === 1'b0 && SCLK === 1'b1 && sclk_q === 1'b0) begin
            if (fl_bits < 32) begin
                fl_in   = {fl_in[30:0], MOSI};
                fl_bits = fl_bits + 1;
                if (fl_bits == 32) begin
                    fl_word  = fl_in;
                    fl_words = fl_words + 1;
                end
            end
        end else if (CS_n === 1'b0 && SCLK === 1'b0 && sclk_q === 1'b1 && fl_bits == 32) begin
            MISO   = flash_mem[(int'(fl_word[23:0]) + fl_out / 8) % MEMSZ][7 - fl_out % 8];
            fl_out = fl_out + 1;
        end
        sclk_q = SCLK;
    end

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       d;
    } pix_t;

    pix_t pix_q[$];
    int   we_consec  = 0;
    int   we_outside = 0;
    int   cs_falls   = 0;
    int   busy_rises = 0;
    logic we_q       = 1'b0;
    logic cs_q       = 1'b1;
    logic busy_q     = 1'b0;
    always @(negedge CLK_40) begin
        if (write_enable === 1'b1) begin
            pix_q.push_back({mem_x_pos, mem_y_pos, data_in});
            if (we_q) we_consec = we_consec + 1;
            if (CS_n !== 1'b0) we_outside = we_outside + 1;
        end
        if (cs_q === 1'b1 && CS_n === 1'b0) cs_falls = cs_falls + 1;
        if (busy_q === 1'b0 && busy === 1'b1) busy_rises = busy_rises + 1;
        we_q   = (write_enable === 1'b1);
        cs_q   = CS_n;
        busy_q = busy;
    end

    // SCLK and MOSI may only move on a tick, a frame start or reset.
    int stab_viol = 0;
    always begin
        logic s_en, s_st, s_rst, s_sclk, s_mosi;
        @(posedge CLK_40);
        s_en   = SPI_clk_en;
        s_st   = frame_start;
        s_rst  = reset;
        s_sclk = SCLK;
        s_mosi = MOSI;
        #1;
        if (!s_en && !s_st && !s_rst && (SCLK !== s_sclk || MOSI !== s_mosi))
            stab_viol = stab_viol + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(negedge CLK_40);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks = n_checks + 1;
        if (actual !== expected) begin
            n_errors = n_errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus();
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            step();
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Reference: pixel p of a frame at byte address a is bit 7-(p%8) of byte a+p/8, at x=p%XW, y=p/XW.
    function automatic int stream_errors(input int base, input logic [23:0] a);
        int bad = 0;
        for (int p = 0; p < NPIX; p++) begin
            pix_t e;
            e.x = 3'(p % XW);
            e.y = 3'(p / XW);
            e.d = flash_mem[(int'(a) + p / 8) % MEMSZ][7 - p % 8];
            if (base + p >= pix_q.size()) bad++;
            else if (pix_q[base + p] !== e) bad++;
        end
        return bad;
    endfunction

    task automatic do_frame(input int gap, input logic [23:0] exp_addr, input string tag);
        int base;
        int words0;
        bit seen;
        tick_max = gap;
        base     = pix_q.size();
        words0   = fl_words;
        apply_stimulus();
        wait_done(seen);
        check_output({tag, "_done"}, 32'(seen), 32'd1);
        check_output({tag, "_cs_n"}, 32'(CS_n), 32'd1);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_reads"}, 32'(fl_words - words0), 32'd1);
        check_output({tag, "_cmd"}, 32'(fl_word[31:24]), 32'h03);
        check_output({tag, "_addr"}, 32'(fl_word[23:0]), 32'(exp_addr));
        check_output({tag, "_strobes"}, 32'(pix_q.size() - base), 32'(NPIX));
        check_output({tag, "_stream"}, 32'(stream_errors(base, exp_addr)), 32'd0);
        last_base = base;
    endtask

    typedef struct {
        int          gap;
        logic [23:0] exp_addr;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [7:0] frame0[6];
        logic [7:0] row2;
        int         base, cf0, br0, words0;
        bit         seen, reached;

        vecs[0] = '{0, 24'd0};
        vecs[1] = '{3, 24'd6};
        vecs[2] = '{6, 24'd12};
        vecs[3] = '{1, 24'd18};
        vecs[4] = '{6, 24'd0};

        frame0 = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h81, 8'h7E};
        for (int i = 0; i < MEMSZ; i++) flash_mem[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) flash_mem[i] = frame0[i];

        repeat (3) step();
        check_output("rst_cs_n", 32'(CS_n), 32'd1);
        check_output("rst_sclk", 32'(SCLK), 32'd0);
        check_output("rst_mosi", 32'(MOSI), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_we", 32'(write_enable), 32'd0);
        check_output("rst_done", 32'(frame_done), 32'd0);
        check_output("rst_xy", 32'({mem_x_pos, mem_y_pos}), 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            do_frame(vecs[i].gap, vecs[i].exp_addr, $sformatf("vec%0d", i));
            if (i == 0) begin
                base = last_base;
                check_output("f0_px00", 32'(pix_q[base].d), 32'd1);
                check_output("f0_px10", 32'(pix_q[base + 1].d), 32'd0);
                for (int k = 0; k < 8; k++) row2[7 - k] = pix_q[base + 16 + k].d;
                check_output("f0_row2", 32'(row2), 32'hFF);
                check_output("f0_last_xy", 32'({pix_q[base + NPIX - 1].x, pix_q[base + NPIX - 1].y}),
                             32'({3'd7, 3'd5}));
            end
        end

        // frame_start during ADDR and in the frame_done cycle must not start another read.
        tick_max = 2;
        base     = pix_q.size();
        cf0      = cs_falls;
        br0      = busy_rises;
        words0   = fl_words;
        apply_stimulus();
        reached = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            step();
            if (fl_bits >= 16) begin
                reached = 1'b1;
                break;
            end
        end
        check_output("ign_in_addr", 32'(reached), 32'd1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        wait_done(seen);
        check_output("ign_done", 32'(seen), 32'd1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (40) step();
        check_output("ign_cs_falls", 32'(cs_falls - cf0), 32'd1);
        check_output("ign_busy_spans", 32'(busy_rises - br0), 32'd1);
        check_output("ign_busy_end", 32'(busy), 32'd0);
        check_output("ign_reads", 32'(fl_words - words0), 32'd1);
        check_output("ign_addr", 32'(fl_word[23:0]), 32'd6);
        check_output("ign_stream", 32'(stream_errors(base, 24'd6)), 32'd0);

        // Reset in the middle of the pixel stream discards the frame and rewinds the frame index.
        tick_max = 1;
        base     = pix_q.size();
        apply_stimulus();
        reached = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            step();
            if (pix_q.size() - base >= 20) begin
                reached = 1'b1;
                break;
            end
        end
        check_output("mid_reached20", 32'(reached), 32'd1);
        reset = 1'b1;
        step();
        check_output("mid_cs_n", 32'(CS_n), 32'd1);
        check_output("mid_busy", 32'(busy), 32'd0);
        check_output("mid_sclk", 32'(SCLK), 32'd0);
        check_output("mid_we", 32'(write_enable), 32'd0);
        reset = 1'b0;
        repeat (10) step();
        check_output("mid_strobes", 32'(pix_q.size() - base), 32'd20);
        do_frame(0, 24'd0, "post_rst");

        check_output("sclk_mosi_stable", 32'(stab_viol), 32'd0);
        check_output("we_consecutive", 32'(we_consec), 32'd0);
        check_output("we_outside_cs", 32'(we_outside), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
